player_motion: RTL

// Per-player kinematics stage. Closes the loop with the elevator/obstacle controllers:
// it consumes the merged X/Y min/max limits they produce and, once per frame, moves
// the player by keyboard intent plus gravity and clamps the result to those limits.
// It drives the player_top/bottom/left/right edges back into the controllers.

---
 rtl/player_motion.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/player_motion.sv
// Per-player kinematics stage: once per frame, moves the player by keyboard
// intent plus gravity and clamps the result to the merged X/Y limits that the
// elevator/obstacle controllers produce. Hitbox edges are fed back to them.
module player_motion #(
    parameter int START_X   = 24,
    parameter int START_Y   = 400,
    parameter int PLAYER_W  = 24,
    parameter int PLAYER_H  = 32,
    parameter int MOVE_STEP = 2,
    parameter int JUMP_V0   = 8,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               key_jump,
    input  logic signed [15:0] X_Min,
    input  logic signed [15:0] X_Max,
    input  logic signed [15:0] Y_Min,
    input  logic signed [15:0] Y_Max,
    output logic signed [15:0] player_top,
    output logic signed [15:0] player_bottom,
    output logic signed [15:0] player_left,
    output logic signed [15:0] player_right,
    output logic               on_ground,
    output logic               facing_left,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        GROUND = 2'b00,
        JUMP   = 2'b01,
        FALL   = 2'b10,
        UNUSED = 2'b11
    } state_e;

    localparam logic signed [15:0] SX  = 16'(START_X);
    localparam logic signed [15:0] SY  = 16'(START_Y);
    localparam logic signed [15:0] PW  = 16'(PLAYER_W);
    localparam logic signed [15:0] PH  = 16'(PLAYER_H);
    localparam logic signed [15:0] MS  = 16'(MOVE_STEP);
    localparam logic signed [15:0] JV  = 16'(JUMP_V0);
    localparam logic signed [15:0] GR  = 16'(GRAVITY);
    localparam logic signed [15:0] MF  = 16'(MAX_FALL);

    logic               fr_q1, fr_q2;
    logic               upd;
    logic signed [15:0] x_q, x_d;
    logic signed [15:0] y_q, y_d;
    logic signed [15:0] vy_q, vy_d;
    state_e             st_q, st_d;
    logic               face_q, face_d;

    logic signed [15:0] dx, nx, ny, vy_inc;

    // Rising edge of the frame strobe, one cycle wide.
    assign upd = fr_q1 & ~fr_q2;

    // State registers. The frame synchroniser resets high so that a strobe
    // already high around reset cannot produce an update afterwards; only a
    // fresh rise after Reset falls will.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fr_q1  <= 1'b1;
            fr_q2  <= 1'b1;
            x_q    <= SX;
            y_q    <= SY;
            vy_q   <= '0;
            st_q   <= FALL;
            face_q <= 1'b0;
        end else begin
            fr_q1  <= frame_clk;
            fr_q2  <= fr_q1;
            x_q    <= x_d;
            y_q    <= y_d;
            vy_q   <= vy_d;
            st_q   <= st_d;
            face_q <= face_d;
        end
    end

    // Per-frame motion: horizontal step + clamp, vertical FSM + floor/ceiling clamps.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        vy_d   = vy_q;
        st_d   = st_q;
        face_d = face_q;
        dx     = '0;
        nx     = x_q;
        ny     = y_q;
        vy_inc = vy_q + GR;

        if (upd) begin
            if (key_right && !key_left)      dx = MS;
            else if (key_left && !key_right) dx = -MS;
            if (dx != 16'sd0) face_d = key_left;

            // X_Min is applied last so it wins in a window narrower than the player.
            nx = x_q + dx;
            if (nx + PW > X_Max) nx = X_Max - PW;
            if (nx < X_Min)      nx = X_Min;
            x_d = nx;

            case (st_q)
                GROUND: begin
                    if (key_jump) begin
                        vy_d = -JV;
                        ny   = y_q - JV;
                        st_d = JUMP;
                    end else if (y_q + PH > Y_Max) begin
                        ny = Y_Max - PH;
                    end else if (y_q + PH < Y_Max) begin
                        vy_d = '0;
                        st_d = FALL;
                    end
                end
                JUMP: begin
                    vy_d = vy_inc;
                    ny   = y_q + vy_inc;
                    if (ny <= Y_Min) begin
                        ny   = Y_Min;
                        vy_d = '0;
                        st_d = FALL;
                    end else if (vy_inc >= 16'sd0) begin
                        st_d = FALL;
                    end
                end
                default: begin
                    // FALL, and the unreachable 11 encoding treated the same.
                    if (vy_inc > MF) vy_d = MF;
                    else             vy_d = vy_inc;
                    ny   = y_q + vy_d;
                    st_d = FALL;
                    if (ny + PH >= Y_Max) begin
                        ny   = Y_Max - PH;
                        vy_d = '0;
                        st_d = GROUND;
                    end
                end
            endcase

            // Ceiling clamp last: a ceiling below the floor window pins y at Y_Min.
            if (ny < Y_Min) ny = Y_Min;
            y_d = ny;
        end
    end

    assign player_left   = x_q;
    assign player_right  = x_q + PW;
    assign player_top    = y_q;
    assign player_bottom = y_q + PH;
    assign on_ground     = (st_q == GROUND);
    assign facing_left   = face_q;
    assign state         = st_q;

endmodule
